// File: rtl/game_pkg.sv
// Shared definitions for the tic-tac-toe game blocks.
//   - Game-FSM state codes seen on the 'state' bus.
//   - Result codes produced by the winning checker (winning[5:3]).
//   - Enum for the last scored result and the score keeper's own FSM.
//   - Helpers: result decode and a saturating 2-digit BCD increment.
package game_pkg;

    // Game-FSM state codes
    localparam logic [2:0] S_WINNING_CHECKER = 3'b011;
    localparam logic [2:0] S_REFRESHING      = 3'b100;
    localparam logic [2:0] S_UPDATING_SCORE  = 3'b101;

    // Result codes from the winning checker
    localparam logic [2:0] RES_P2   = 3'b110;
    localparam logic [2:0] RES_P1   = 3'b111;
    localparam logic [2:0] RES_DRAW = 3'b100;
    localparam logic [2:0] RES_NONE = 3'b000;

    // Score defaults
    localparam logic [7:0] WIN_TARGET_DEFAULT = 8'h05;
    localparam logic [7:0] MAX_BCD_DEFAULT    = 8'h99;

    // Encoding matches the last_result output port directly
    typedef enum logic [1:0] {
        LR_NONE = 2'b00,
        LR_P1   = 2'b01,
        LR_P2   = 2'b10,
        LR_DRAW = 2'b11
    } last_result_e;

    typedef enum logic [1:0] {
        SK_IDLE,
        SK_CAPTURE,
        SK_INCR,
        SK_DONE
    } sk_state_e;

    // Any code not listed (including RES_NONE) scores nothing
    function automatic last_result_e decode_result(input logic [2:0] code);
        last_result_e r;
        case (code)
            RES_P1:   r = LR_P1;
            RES_P2:   r = LR_P2;
            RES_DRAW: r = LR_DRAW;
            default:  r = LR_NONE;
        endcase
        return r;
    endfunction

    // Two-digit BCD +1; holds at max_v instead of wrapping.
    // Valid BCD orders the same as binary, so a plain compare is enough.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                           input logic [7:0] max_v);
        logic [7:0] r;
        if (v >= max_v)
            r = v;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

endpackage

// File: rtl/bcd_counter8.sv
// Two-digit BCD counter that saturates at MAX_BCD.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous, active-high reset (highest priority)
//   clr   in   zero the count on the next clock (beats inc)
//   inc   in   add one (BCD) on the next clock
//   count out  current BCD value
module bcd_counter8
    import game_pkg::*;
#(
    parameter logic [7:0] MAX_BCD = MAX_BCD_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst)
            count <= 8'h00;
        else if (clr)
            count <= 8'h00;
        else if (inc)
            count <= bcd_inc(count, MAX_BCD);
    end

endmodule

// File: rtl/score_keeper.sv
// Score keeper: runs once per entry of the game FSM into its score-update
// state, capturing the checker's result code, bumping the matching BCD
// counter and tracking match-over. update_done tells the game FSM it may
// move on.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   state          current game-FSM state
//   winning        checker result: [5:3] result code, [2:0] line index
//   clear_scores   single-cycle request to zero scores and match flag
//   score_p1/p2    BCD wins of player 01 / player 10
//   draws          BCD draw count
//   update_done    scoring for this game finished (held while in S_UPDATING)
//   last_result    00 none, 01 p1, 10 p2, 11 draw
//   last_line      line of the last scored win (000 for draw / none)
//   match_over     a player reached WIN_TARGET
//   match_winner   01 or 10 while match_over, else 00
module score_keeper
    import game_pkg::*;
#(
    parameter logic [2:0] S_UPDATING = S_UPDATING_SCORE,
    parameter logic [7:0] WIN_TARGET = WIN_TARGET_DEFAULT,
    parameter logic [7:0] MAX_BCD    = MAX_BCD_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] state,
    input  logic [5:0] winning,
    input  logic       clear_scores,
    output logic [7:0] score_p1,
    output logic [7:0] score_p2,
    output logic [7:0] draws,
    output logic       update_done,
    output logic [1:0] last_result,
    output logic [2:0] last_line,
    output logic       match_over,
    output logic [1:0] match_winner
);

    sk_state_e    fsm;
    logic [5:0]   result_q;    // winning code captured in CAPTURE
    logic         aborted;     // game FSM left S_UPDATING during CAPTURE
    last_result_e last_result_q;
    last_result_e res_kind;
    logic         in_updating;
    logic         inc_p1;
    logic         inc_p2;
    logic         inc_draw;

    assign in_updating = (state == S_UPDATING);
    assign res_kind    = decode_result(result_q[5:3]);

    // Counters only move in INCR and never once the match is decided;
    // clear_scores is applied inside the counters with priority over inc.
    assign inc_p1   = (fsm == SK_INCR) && !match_over && (res_kind == LR_P1);
    assign inc_p2   = (fsm == SK_INCR) && !match_over && (res_kind == LR_P2);
    assign inc_draw = (fsm == SK_INCR) && !match_over && (res_kind == LR_DRAW);

    bcd_counter8 #(.MAX_BCD(MAX_BCD)) u_cnt_p1 (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear_scores),
        .inc   (inc_p1),
        .count (score_p1)
    );

    bcd_counter8 #(.MAX_BCD(MAX_BCD)) u_cnt_p2 (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear_scores),
        .inc   (inc_p2),
        .count (score_p2)
    );

    bcd_counter8 #(.MAX_BCD(MAX_BCD)) u_cnt_draw (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear_scores),
        .inc   (inc_draw),
        .count (draws)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm           <= SK_IDLE;
            result_q      <= 6'b000_000;
            aborted       <= 1'b0;
            update_done   <= 1'b0;
            last_result_q <= LR_NONE;
            last_line     <= 3'b000;
            match_over    <= 1'b0;
            match_winner  <= 2'b00;
        end else begin
            case (fsm)
                SK_IDLE: begin
                    update_done <= 1'b0;
                    if (in_updating)
                        fsm <= SK_CAPTURE;
                end

                SK_CAPTURE: begin
                    result_q <= winning;
                    aborted  <= !in_updating;
                    fsm      <= SK_INCR;
                end

                SK_INCR: begin
                    last_result_q <= res_kind;
                    last_line     <= ((res_kind == LR_P1) || (res_kind == LR_P2))
                                     ? result_q[2:0] : 3'b000;
                    // Compare against the value the counter is about to take.
                    if (!match_over) begin
                        if ((res_kind == LR_P1) &&
                            (bcd_inc(score_p1, MAX_BCD) == WIN_TARGET)) begin
                            match_over   <= 1'b1;
                            match_winner <= LR_P1;
                        end else if ((res_kind == LR_P2) &&
                                     (bcd_inc(score_p2, MAX_BCD) == WIN_TARGET)) begin
                            match_over   <= 1'b1;
                            match_winner <= LR_P2;
                        end
                    end
                    // The update always completes; done is only reported if
                    // the game FSM is still waiting for it.
                    if (aborted || !in_updating) begin
                        fsm <= SK_IDLE;
                    end else begin
                        fsm         <= SK_DONE;
                        update_done <= 1'b1;
                    end
                end

                SK_DONE: begin
                    if (!in_updating) begin
                        update_done <= 1'b0;
                        fsm         <= SK_IDLE;
                    end
                end

                default: fsm <= SK_IDLE;
            endcase

            // NOTE: this sits after the case on purpose -- the last
            // non-blocking assignment to a flop wins, so a clear overrides
            // anything INCR scheduled above while leaving the FSM alone.
            if (clear_scores) begin
                last_result_q <= LR_NONE;
                last_line     <= 3'b000;
                match_over    <= 1'b0;
                match_winner  <= 2'b00;
            end
        end
    end

    assign last_result = last_result_q;

endmodule
